// File: rtl/core_ibex_instr_capture_buf.sv
// rtl/core_ibex_instr_capture_buf.sv - FWFT capture buffer of ID-stage instructions with control-flow check
module core_ibex_instr_capture_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CHECK_FLOW = 1
) (
    input  logic                          clk,
    input  logic                          rst_ni,
    input  logic                          valid_id,
    input  logic                          err_id,
    input  logic                          is_compressed_id,
    input  logic [15:0]                   instr_compressed_id,
    input  logic [DATA_WIDTH-1:0]         instr_id,
    input  logic [DATA_WIDTH-1:0]         pc_id,
    input  logic                          branch_taken_id,
    input  logic [DATA_WIDTH-1:0]         branch_target_id,
    input  logic                          flush_i,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_pc,
    output logic [DATA_WIDTH-1:0]         out_instr,
    output logic                          out_compressed,
    output logic                          out_err,
    output logic                          out_flow_err,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [15:0]                   overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic [DEPTH-1:0]      comp_mem;
    logic [DEPTH-1:0]      err_mem;
    logic [DEPTH-1:0]      flow_mem;

    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_next;
    logic                  exp_valid;
    logic [DATA_WIDTH-1:0] exp_pc;
    logic [DATA_WIDTH-1:0] exp_pc_next;

    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  wr_en;
    logic                  drop;
    logic                  flow_err_id;
    logic [DATA_WIDTH-1:0] instr_store;

    assign full        = (cnt_q == FULL_CNT);
    assign out_valid   = (cnt_q != '0);
    assign push        = valid_id && !flush_i;
    assign pop         = out_valid && out_ready && !flush_i;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign wr_en       = push && (!full || pop);
    assign drop        = push && full && !pop;
    assign flow_err_id = (CHECK_FLOW != 0) && exp_valid && (pc_id != exp_pc);
    assign instr_store = is_compressed_id ? DATA_WIDTH'(instr_compressed_id) : instr_id;

    always_comb begin
        exp_pc_next = pc_id + DATA_WIDTH'(4);
        if (branch_taken_id) begin
            exp_pc_next = branch_target_id;
        end else if (is_compressed_id) begin
            exp_pc_next = pc_id + DATA_WIDTH'(2);
        end
    end

    always_comb begin
        cnt_next = cnt_q;
        case ({wr_en, pop})
            2'b10:   cnt_next = cnt_q + CW'(1);
            2'b01:   cnt_next = cnt_q - CW'(1);
            default: cnt_next = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_ni && wr_en) begin
            pc_mem[wptr]    <= pc_id;
            instr_mem[wptr] <= instr_store;
            comp_mem[wptr]  <= is_compressed_id;
            err_mem[wptr]   <= err_id;
            flow_mem[wptr]  <= flow_err_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            wptr         <= '0;
            rptr         <= '0;
            cnt_q        <= '0;
            exp_valid    <= 1'b0;
            exp_pc       <= '0;
            overflow_cnt <= '0;
        end else if (flush_i) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt_q     <= '0;
            exp_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            cnt_q <= cnt_next;
            if (drop && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
            // Dropped captures still advance the expected-PC context.
            if (valid_id) begin
                exp_valid <= 1'b1;
                exp_pc    <= exp_pc_next;
            end
        end
    end

    assign count          = cnt_q;
    assign out_pc         = pc_mem[rptr];
    assign out_instr      = instr_mem[rptr];
    assign out_compressed = comp_mem[rptr];
    assign out_err        = err_mem[rptr];
    assign out_flow_err   = flow_mem[rptr];

endmodule

// File: tb/tb_core_ibex_instr_capture_buf.sv
// tb/tb_core_ibex_instr_capture_buf.sv - directed vector bench for core_ibex_instr_capture_buf
module tb_core_ibex_instr_capture_buf;

    logic        clk;
    logic        rst_ni;
    logic        valid_id;
    logic        err_id;
    logic        is_compressed_id;
    logic [15:0] instr_compressed_id;
    logic [31:0] instr_id;
    logic [31:0] pc_id;
    logic        branch_taken_id;
    logic [31:0] branch_target_id;
    logic        flush_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_compressed;
    logic        out_err;
    logic        out_flow_err;
    logic [3:0]  count;
    logic [15:0] overflow_cnt;

    int total;
    int bad;

    core_ibex_instr_capture_buf #(
        .DATA_WIDTH (32),
        .DEPTH      (8),
        .CHECK_FLOW (1)
    ) dut (
        .clk                 (clk),
        .rst_ni              (rst_ni),
        .valid_id            (valid_id),
        .err_id              (err_id),
        .is_compressed_id    (is_compressed_id),
        .instr_compressed_id (instr_compressed_id),
        .instr_id            (instr_id),
        .pc_id               (pc_id),
        .branch_taken_id     (branch_taken_id),
        .branch_target_id    (branch_target_id),
        .flush_i             (flush_i),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_pc              (out_pc),
        .out_instr           (out_instr),
        .out_compressed      (out_compressed),
        .out_err             (out_err),
        .out_flow_err        (out_flow_err),
        .count               (count),
        .overflow_cnt        (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic        err;
        logic        comp;
        logic [15:0] ic;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        br;
        logic [31:0] tgt;
        logic        flush;
        logic        ready;
        logic        e_valid;
        logic [3:0]  e_count;
        logic [15:0] e_ovf;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_comp;
        logic        e_err;
        logic        e_flow;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst_ni              = 1'b1;
        valid_id            = 1'b0;
        err_id              = 1'b0;
        is_compressed_id    = 1'b0;
        instr_compressed_id = 16'h0;
        instr_id            = 32'h0;
        pc_id               = 32'h0;
        branch_taken_id     = 1'b0;
        branch_target_id    = 32'h0;
        flush_i             = 1'b0;
        out_ready           = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pc(input logic [31:0] pc, input logic rdy);
        idle();
        valid_id  = 1'b1;
        pc_id     = pc;
        instr_id  = pc ^ 32'h0000_0013;
        out_ready = rdy;
        step();
    endtask

    task automatic pop_one();
        idle();
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();

        //            rst v  e  c  ic       instr         pc            br tgt           fl rdy  ev cnt ovf   e_pc          e_instr       ec ee ef
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,16'h0,   32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b0, 1'b0,4'd0,16'd0,32'h0,        32'h0,        1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b1,1'b0,1'b0,16'h0,   32'h0000_0013,32'h0000_0080,1'b0,32'h0,        1'b0,1'b0, 1'b1,4'd1,16'd0,32'h0000_0080,32'h0000_0013,1'b0,1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b1,1'b0,1'b1,16'h4501,32'h0005_0513,32'h0000_0084,1'b0,32'h0,        1'b0,1'b0, 1'b1,4'd2,16'd0,32'h0000_0080,32'h0000_0013,1'b0,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,16'h0,   32'h00a0_0093,32'h0000_0086,1'b0,32'h0,        1'b0,1'b0, 1'b1,4'd3,16'd0,32'h0000_0080,32'h0000_0013,1'b0,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,16'h0,   32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b1,4'd2,16'd0,32'h0000_0084,32'h0000_4501,1'b1,1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,16'h0,   32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b1,4'd1,16'd0,32'h0000_0086,32'h00a0_0093,1'b0,1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,16'h0,   32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b0,4'd0,16'd0,32'h0,        32'h0,        1'b0,1'b0,1'b0};
        // 0x100 follows 0x86 (expected 0x8a), so it is itself a flow break
        tbl[7]  = '{1'b1,1'b1,1'b0,1'b0,16'h0,   32'h0000_0063,32'h0000_0100,1'b1,32'h0000_0200,1'b0,1'b0, 1'b1,4'd1,16'd0,32'h0000_0100,32'h0000_0063,1'b0,1'b0,1'b1};
        tbl[8]  = '{1'b1,1'b1,1'b1,1'b0,16'h0,   32'h0000_0001,32'h0000_0104,1'b0,32'h0,        1'b0,1'b1, 1'b1,4'd1,16'd0,32'h0000_0104,32'h0000_0001,1'b0,1'b1,1'b1};
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b0,16'h0,   32'h0000_0002,32'h0000_0108,1'b0,32'h0,        1'b0,1'b1, 1'b1,4'd1,16'd0,32'h0000_0108,32'h0000_0002,1'b0,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b0,1'b0,1'b0,16'h0,   32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b0,4'd0,16'd0,32'h0,        32'h0,        1'b0,1'b0,1'b0};
        tbl[11] = '{1'b1,1'b1,1'b0,1'b0,16'h0,   32'h0000_0003,32'h0000_010c,1'b0,32'h0,        1'b0,1'b1, 1'b1,4'd1,16'd0,32'h0000_010c,32'h0000_0003,1'b0,1'b0,1'b0};
        tbl[12] = '{1'b1,1'b0,1'b0,1'b0,16'h0,   32'h0,        32'h0,        1'b0,32'h0,        1'b0,1'b1, 1'b0,4'd0,16'd0,32'h0,        32'h0,        1'b0,1'b0,1'b0};

        for (int i = 0; i < 13; i++) begin
            rst_ni              = tbl[i].rst_n;
            valid_id            = tbl[i].valid;
            err_id              = tbl[i].err;
            is_compressed_id    = tbl[i].comp;
            instr_compressed_id = tbl[i].ic;
            instr_id            = tbl[i].instr;
            pc_id               = tbl[i].pc;
            branch_taken_id     = tbl[i].br;
            branch_target_id    = tbl[i].tgt;
            flush_i             = tbl[i].flush;
            out_ready           = tbl[i].ready;
            step();
            check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            check($sformatf("v%0d.count", i), 32'(count), 32'(tbl[i].e_count));
            check($sformatf("v%0d.overflow_cnt", i), 32'(overflow_cnt), 32'(tbl[i].e_ovf));
            if (tbl[i].e_valid) begin
                check($sformatf("v%0d.out_pc", i), out_pc, tbl[i].e_pc);
                check($sformatf("v%0d.out_instr", i), out_instr, tbl[i].e_instr);
                check($sformatf("v%0d.out_compressed", i), 32'(out_compressed), 32'(tbl[i].e_comp));
                check($sformatf("v%0d.out_err", i), 32'(out_err), 32'(tbl[i].e_err));
                check($sformatf("v%0d.out_flow_err", i), 32'(out_flow_err), 32'(tbl[i].e_flow));
            end
        end

        // Overflow: 10 pushes into an 8-deep buffer, last two dropped
        for (int i = 0; i < 10; i++) begin
            push_pc(32'h200 + 32'(4 * i), 1'b0);
        end
        check("ovf.count", 32'(count), 32'd8);
        check("ovf.overflow_cnt", 32'(overflow_cnt), 32'd2);
        check("ovf.head_pc", out_pc, 32'h200);

        // Full with push+pop; 0x228 matches the context advanced by the dropped pushes
        push_pc(32'h228, 1'b1);
        check("fullpp.count", 32'(count), 32'd8);
        check("fullpp.overflow_cnt", 32'(overflow_cnt), 32'd2);
        check("fullpp.head_pc", out_pc, 32'h204);
        for (int k = 1; k <= 7; k++) begin
            pop_one();
            check($sformatf("drain%0d.count", k), 32'(count), 32'(8 - k));
            check($sformatf("drain%0d.head_pc", k), out_pc, (k < 7) ? 32'h204 + 32'(4 * k) : 32'h228);
        end
        check("tail.out_flow_err", 32'(out_flow_err), 32'd0);
        check("tail.out_instr", out_instr, 32'h228 ^ 32'h13);
        pop_one();
        check("drained.out_valid", 32'(out_valid), 32'd0);

        // Flush after 3 pushes, with valid_id and out_ready asserted during flush
        push_pc(32'h400, 1'b0);
        push_pc(32'h404, 1'b0);
        push_pc(32'h408, 1'b0);
        check("preflush.count", 32'(count), 32'd3);
        idle();
        flush_i   = 1'b1;
        valid_id  = 1'b1;
        pc_id     = 32'h500;
        out_ready = 1'b1;
        step();
        check("flush.count", 32'(count), 32'd0);
        check("flush.out_valid", 32'(out_valid), 32'd0);
        check("flush.overflow_cnt", 32'(overflow_cnt), 32'd2);
        push_pc(32'h999, 1'b0);
        check("postflush.count", 32'(count), 32'd1);
        check("postflush.head_pc", out_pc, 32'h999);
        check("postflush.out_flow_err", 32'(out_flow_err), 32'd0);

        // Reset mid-stream with 5 held entries and overflow_cnt=3
        for (int i = 0; i < 8; i++) begin
            push_pc(32'h600 + 32'(4 * i), 1'b0);
        end
        pop_one();
        pop_one();
        pop_one();
        check("prereset.count", 32'(count), 32'd5);
        check("prereset.overflow_cnt", 32'(overflow_cnt), 32'd3);
        idle();
        rst_ni    = 1'b0;
        valid_id  = 1'b1;
        pc_id     = 32'h700;
        out_ready = 1'b1;
        step();
        check("reset.count", 32'(count), 32'd0);
        check("reset.overflow_cnt", 32'(overflow_cnt), 32'd0);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        idle();
        step();
        check("postreset.count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
